// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the multiplexed 7-segment scanner.
//   - phase_e    : slot phase (SHOW / GAP)
//   - SEG_BLANK  : all segments off, active-high
//   - SEG_TABLE  : 16-entry hex glyph table, bit 6 = a ... bit 0 = g
//   - hex_to_seg7: nibble -> active-high segment pattern
package seg7_pkg;

    typedef enum logic {
        PH_SHOW = 1'b0,
        PH_GAP  = 1'b1
    } phase_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Packed so that SEG_TABLE[n] is the glyph for nibble n; the list runs F down to 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to 7-segment decoder (active-high).
// Ports:
//   nibble in  [3:0] hex value
//   seg    out [6:0] segments, seg[6]=a ... seg[0]=g
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg7(nibble);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment display scanner.
// Scans DIGITS common-enable digits from a packed hex word, one digit per
// DIV-cycle slot, with a GAP-cycle blanking tail per slot, frame-coherent
// latching of data/dp/blank_lz, leading-zero blanking and output polarity.
// Optional macro SEG7_DIM_EN adds a 4-bit brightness input (PWM on cnt[3:0]).
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   data        in   [4*DIGITS-1:0] hex nibbles, digit 0 rightmost
//   dp          in   [DIGITS-1:0] decimal point per digit
//   blank_lz    in   enable leading-zero blanking
//   brightness  in   [3:0] duty (SEG7_DIM_EN builds only)
//   en          out  [DIGITS-1:0] digit enable, one-hot or none active
//   seg         out  [6:0] segments a..g
//   seg_dp      out  decimal point segment
//   frame_start out  one-cycle pulse with the first enable of digit 0
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIV        = 1024,
    parameter int GAP        = 16,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
`ifdef SEG7_DIM_EN
    input  logic [3:0]            brightness,
`endif
    output logic [DIGITS-1:0]     en,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic                  frame_start
);

    localparam int CW  = $clog2(DIV);
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   frm_data_q, frm_data_d;
    logic [DIGITS-1:0]     frm_dp_q, frm_dp_d;
    logic                  frm_lz_q, frm_lz_d;

    logic [DIGITS-1:0]     en_q, en_d;
    logic [6:0]            seg_q, seg_d;
    logic                  seg_dp_q, seg_dp_d;
    logic                  frame_start_q, frame_start_d;

    logic                  slot_end;
    logic                  last_digit;
    phase_e                phase;
    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  blank_sel;
    logic [DIGITS-1:0]     onehot;
    logic [6:0]            dec_seg;
    logic                  dim_ok;
    logic [DIGITS-1:0]     en_raw;
    logic [6:0]            seg_raw;
    logic                  dp_raw;

`ifdef SEG7_DIM_EN
    logic [31:0]           cnt_ext;
`endif

    // Scan position and frame latch.
    always_comb begin
        slot_end   = (cnt_q == CW'(DIV - 1));
        last_digit = (idx_q == IW'(DIGITS - 1));

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;

        idx_d = idx_q;
        if (slot_end) begin
            idx_d = last_digit ? '0 : idx_q + 1'b1;
        end

        frm_data_d = frm_data_q;
        frm_dp_d   = frm_dp_q;
        frm_lz_d   = frm_lz_q;
        if (slot_end && last_digit) begin
            frm_data_d = data;
            frm_dp_d   = dp;
            frm_lz_d   = blank_lz;
        end
    end

    // Digit select: the loop picks the current nibble/dp and decides whether
    // the digit is a leading zero (its nibble and all nibbles above are zero).
    always_comb begin
        nib_sel   = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        onehot    = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            onehot[i] = (IW'(i) == idx_q);
            if (IW'(i) == idx_q) begin
                nib_sel   = frm_data_q[4*i +: 4];
                dp_sel    = frm_dp_q[i];
                blank_sel = frm_lz_q && (i != 0) && ((frm_data_q >> (4*i)) == '0);
            end
        end
    end

    seg7_decode u_decode (
        .nibble (nib_sel),
        .seg    (dec_seg)
    );

    always_comb begin
        phase = (32'(cnt_q) < 32'(DIV - GAP)) ? PH_SHOW : PH_GAP;

`ifdef SEG7_DIM_EN
        cnt_ext = 32'(cnt_q);
        dim_ok  = (cnt_ext[3:0] <= brightness);
`else
        dim_ok  = 1'b1;
`endif

        en_raw  = '0;
        seg_raw = SEG_BLANK;
        dp_raw  = 1'b0;
        if (phase == PH_SHOW && dim_ok) begin
            en_raw  = onehot;
            seg_raw = blank_sel ? SEG_BLANK : dec_seg;
            dp_raw  = dp_sel;
        end

        en_d          = en_raw  ^ {DIGITS{INV}};
        seg_d         = seg_raw ^ {7{INV}};
        seg_dp_d      = dp_raw  ^ INV;
        frame_start_d = (cnt_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            frm_data_q    <= '0;
            frm_dp_q      <= '0;
            frm_lz_q      <= 1'b0;
            en_q          <= {DIGITS{INV}};
            seg_q         <= {7{INV}};
            seg_dp_q      <= INV;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frm_data_q    <= frm_data_d;
            frm_dp_q      <= frm_dp_d;
            frm_lz_q      <= frm_lz_d;
            en_q          <= en_d;
            seg_q         <= seg_d;
            seg_dp_q      <= seg_dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign en          = en_q;
    assign seg         = seg_q;
    assign seg_dp      = seg_dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl: two instances (4 digits / DIV 8 / GAP 2,
// active-high, and 3 digits / DIV 5 / GAP 0, active-low) driven with random
// data; a cycle-count reference model queues expected outputs and monitors
// compare them on the falling edge.
module tb_seg7_scan_ctrl;

    typedef struct packed {
        logic [7:0] en;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [15:0] data_a = '0;
    logic [3:0]  dp_a   = '0;
    logic        lz_a   = 1'b0;
    logic [3:0]  en_a;
    logic [6:0]  seg_a;
    logic        sdp_a, fs_a;

    logic [11:0] data_b = '0;
    logic [2:0]  dp_b   = '0;
    logic        lz_b   = 1'b0;
    logic [2:0]  en_b;
    logic [6:0]  seg_b;
    logic        sdp_b, fs_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIGITS(4), .DIV(8), .GAP(2), .ACTIVE_LOW(0)) u_a (
        .clk(clk), .rst_n(rst_n), .data(data_a), .dp(dp_a), .blank_lz(lz_a),
        .en(en_a), .seg(seg_a), .seg_dp(sdp_a), .frame_start(fs_a)
    );

    seg7_scan_ctrl #(.DIGITS(3), .DIV(5), .GAP(0), .ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst_n(rst_n), .data(data_b), .dp(dp_b), .blank_lz(lz_b),
        .en(en_b), .seg(seg_b), .seg_dp(sdp_b), .frame_start(fs_b)
    );

    function automatic logic [6:0] ref_glyph(input int n);
        case (n)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
            10: return 7'b1110111;
            11: return 7'b0011111;
            12: return 7'b1001110;
            13: return 7'b0111101;
            14: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    function automatic exp_t idle_out(input int nd, input bit al);
        exp_t e;
        e.en  = al ? 8'((1 << nd) - 1) : 8'd0;
        e.seg = al ? 7'h7f : 7'h00;
        e.dp  = al;
        e.fs  = 1'b0;
        return e;
    endfunction

    // t = cycles since reset release; the slot, digit and frame follow from it.
    function automatic exp_t model_out(input int nd, input int dv, input int gp, input bit al,
                                       input int t, input int unsigned fd,
                                       input int unsigned fdp, input bit flz);
        exp_t e;
        int digit = (t / dv) % nd;
        int pos   = t % dv;
        int unsigned upper = fd >> (4 * digit);
        e = '0;
        e.fs = ((t % (nd * dv)) == 0);
        if (pos < dv - gp) begin
            e.en  = 8'(1 << digit);
            e.seg = (flz && digit > 0 && upper == 0) ? 7'h00 : ref_glyph(int'(upper & 15));
            e.dp  = fdp[digit];
        end
        if (al) begin
            e.en  = ~e.en & 8'((1 << nd) - 1);
            e.seg = ~e.seg;
            e.dp  = ~e.dp;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, want);
        end
    endtask

    // Reference models: one expectation per clock edge.
    int t_a = 0, t_b = 0;
    int unsigned fd_a = 0, fdp_a = 0, fd_b = 0, fdp_b = 0;
    bit flz_a = 0, flz_b = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            t_a = 0; fd_a = 0; fdp_a = 0; flz_a = 0;
            t_b = 0; fd_b = 0; fdp_b = 0; flz_b = 0;
            q_a.push_back(idle_out(4, 1'b0));
            q_b.push_back(idle_out(3, 1'b1));
        end else begin
            q_a.push_back(model_out(4, 8, 2, 1'b0, t_a, fd_a, fdp_a, flz_a));
            q_b.push_back(model_out(3, 5, 0, 1'b1, t_b, fd_b, fdp_b, flz_b));
            if (t_a % 32 == 31) begin
                fd_a = 32'(data_a); fdp_a = 32'(dp_a); flz_a = lz_a;
            end
            if (t_b % 15 == 14) begin
                fd_b = 32'(data_b); fdp_b = 32'(dp_b); flz_b = lz_b;
            end
            t_a++;
            t_b++;
        end
    end

    // Monitors.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("a_en",  int'(en_a),  int'(e.en[3:0]));
            chk("a_seg", int'(seg_a), int'(e.seg));
            chk("a_dp",  int'(sdp_a), int'(e.dp));
            chk("a_fs",  int'(fs_a),  int'(e.fs));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("b_en",  int'(en_b),  int'(e.en[2:0]));
            chk("b_seg", int'(seg_b), int'(e.seg));
            chk("b_dp",  int'(sdp_b), int'(e.dp));
            chk("b_fs",  int'(fs_b),  int'(e.fs));
        end
    end

    // Random hex word with a random number of significant nibbles, so leading
    // zeros and all-zero words show up often.
    function automatic int unsigned gen_word(input int nd);
        int unsigned r = $urandom;
        int keep = $urandom_range(0, nd);
        if ($urandom_range(0, 7) == 0) return 32'h40;
        if (keep == 0) return 0;
        return r & ((keep >= 8) ? 32'hffff_ffff : ((32'h1 << (4 * keep)) - 1));
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            if (i == 700 || i == 1203) rst_n = 1'b0;
            if (i == 702 || i == 1204) rst_n = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                data_a = 16'(gen_word(4));
                dp_a   = 4'($urandom);
                lz_a   = ($urandom_range(0, 2) != 0);
            end
            if ($urandom_range(0, 9) == 0) begin
                data_b = 12'(gen_word(3));
                dp_b   = 3'($urandom);
                lz_b   = ($urandom_range(0, 2) != 0);
            end
        end
        repeat (2) @(negedge clk);
        #1;
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
        if (checks < 12) begin
            failures++;
            $display("FAIL too_few_checks actual=%0d expected>=12", checks);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
